psum_ofifo_bank: RTL

- Parametrised output FIFO bank between the MAC array's south outputs and the SFU/SRAM write-back path. Successor to the single-depth column OFIFO.
- Each column has an independent circular queue, written by that column's valid strobe. Reads pop one complete row, one entry per column, only when every column holds data.
- Adds configurable depth, occupancy reporting, sticky overflow/underflow flags and an optional ReLU on the read path.

---
 rtl/psum_ofifo_bank_if.sv | 43 ++++
 rtl/psum_ofifo_bank.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/psum_ofifo_bank_if.sv
// psum_ofifo_bank_if
//   Bundles the data/handshake signals of the psum output FIFO bank.
//   master : producer/consumer side (MAC array south outputs + write-back reader)
//   slave  : the FIFO bank itself
//   Signals:
//     in          col*psum_bw  column c psum on bits [c*psum_bw +: psum_bw]
//     wr          col          per-column write strobe
//     rd          1            pop one full row
//     out         col*psum_bw  registered row output
//     o_full      1            any column queue full
//     o_ready     1            ~o_full
//     o_valid     1            every column queue non-empty
//     o_count     clog2(D)+1   complete rows available
//     o_overflow  1            sticky dropped-write flag
//     o_underflow 1            sticky empty-read flag
interface psum_ofifo_bank_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int DEPTH   = 64
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [col*psum_bw-1:0] in;
   logic [col-1:0]         wr;
   logic                   rd;
   logic [col*psum_bw-1:0] out;
   logic                   o_full;
   logic                   o_ready;
   logic                   o_valid;
   logic [CW-1:0]          o_count;
   logic                   o_overflow;
   logic                   o_underflow;

   modport master (
      output in, wr, rd,
      input  out, o_full, o_ready, o_valid, o_count, o_overflow, o_underflow
   );

   modport slave (
      input  in, wr, rd,
      output out, o_full, o_ready, o_valid, o_count, o_overflow, o_underflow
   );
endinterface

// File: rtl/psum_ofifo_bank.sv
// psum_ofifo_bank
//   Output FIFO bank between the MAC array south outputs and write-back.
//   One independent circular queue per column, each written by its own
//   strobe; a read pops one aligned row (one entry per column) only when
//   every column holds data. Row data is registered on the pop edge.
//   Ports:
//     clk    clock
//     reset  synchronous active-high reset
//     bus    psum_ofifo_bank_if.slave (in/wr/rd in; out and status out)
//   Optional feature: define OFIFO_RELU_EN to clamp negative values to 0
//   on the way into out (stored data is never modified).

// Single column queue. Pointers wrap naturally because DEPTH is a power of 2.
module psum_ofifo_col #(
   parameter int psum_bw = 16,
   parameter int DEPTH   = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [psum_bw-1:0]       din,
   input  logic                     wr,
   input  logic                     pop,    // only asserted when every column is non-empty
   output logic [psum_bw-1:0]       head,
   output logic [$clog2(DEPTH):0]   occ,
   output logic                     full,
   output logic                     drop
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   logic [psum_bw-1:0] mem [DEPTH];
   logic [AW-1:0]      wptr;
   logic [AW-1:0]      rptr;
   logic [AW:0]        occ_q;
   logic               wr_ok;

   assign full  = (occ_q == FULL_OCC);
   // A pop in the same cycle frees the slot, so a full column may still accept.
   assign wr_ok = wr & (~full | pop);
   assign drop  = wr & full & ~pop;
   assign head  = mem[rptr];
   assign occ   = occ_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         occ_q <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (pop)   rptr <= rptr + 1'b1;
         case ({wr_ok, pop})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers/occupancy.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) mem[wptr] <= din;
   end
endmodule

module psum_ofifo_bank #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int DEPTH   = 64
) (
   input  logic               clk,
   input  logic               reset,
   psum_ofifo_bank_if.slave   bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [col-1:0][psum_bw-1:0] head;
   logic [col-1:0][psum_bw-1:0] row_d;
   logic [col-1:0][psum_bw-1:0] out_q;
   logic [col-1:0][CW-1:0]      occ;
   logic [col-1:0]              full;
   logic [col-1:0]              drop;
   logic [CW-1:0]               min_occ;
   logic                        valid;
   logic                        pop;
   logic                        ovf_q;
   logic                        udf_q;

   for (genvar c = 0; c < col; c++) begin : g_col
      psum_ofifo_col #(.psum_bw(psum_bw), .DEPTH(DEPTH)) u_col (
         .clk  (clk),
         .reset(reset),
         .din  (bus.in[c*psum_bw +: psum_bw]),
         .wr   (bus.wr[c]),
         .pop  (pop),
         .head (head[c]),
         .occ  (occ[c]),
         .full (full[c]),
         .drop (drop[c])
      );
   end

   // Complete rows available = least-filled column.
   always_comb begin
      min_occ = occ[0];
      for (int c = 1; c < col; c++)
         if (occ[c] < min_occ) min_occ = occ[c];
   end

   assign valid = (min_occ != '0);
   assign pop   = bus.rd & valid;

   always_comb begin
      row_d = head;
`ifdef OFIFO_RELU_EN
      for (int c = 0; c < col; c++)
         if (head[c][psum_bw-1]) row_d[c] = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (pop)              out_q <= row_d;
         if (|drop)            ovf_q <= 1'b1;
         if (bus.rd && !valid) udf_q <= 1'b1;
      end
   end

   assign bus.out         = out_q;
   assign bus.o_count     = min_occ;
   assign bus.o_valid     = valid;
   assign bus.o_full      = |full;
   assign bus.o_ready     = ~(|full);
   assign bus.o_overflow  = ovf_q;
   assign bus.o_underflow = udf_q;
endmodule
